fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle instruction-fetch controller for the RV32I core. Owns the architectural PC register,
//  fetches from instruction memory over a req/ready handshake, presents the instruction to decode/execute,
//  then commits the next PC from the execute stage's pc_src/rs1/imm/alu_result via the next-PC mux.
//  Sits between imem and the decode/execute datapath; the only writer of pc.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  TRAP_VECTOR  32'h0000_0010  PC loaded on misaligned-target trap (MISALIGN_TRAP_EN only)
//  CNT_W        32             width of retired-instruction counter
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   reset, synchronous, active-low
//  imem_req     out  1   fetch request; held high until imem_ready
//  imem_addr    out  32  fetch address (= pc while imem_req)
//  imem_ready   in   1   imem accepts request and returns imem_rdata this cycle
//  imem_rdata   in   32  instruction word, valid when imem_req && imem_ready
//  instr        out  32  registered instruction to decode
//  instr_valid  out  1   high throughout EXEC
//  exec_done    in   1   execute finished; pc_src/rs1/imm/alu_result valid this cycle
//  pc_src       in   2   00 JALR, 01 JAL, 10 branch, 11 sequential
//  rs1, imm     in   32  JALR base / sign-extended immediate
//  alu_result   in   32  branch predicate; taken iff == 32'h1
//  halt         in   1   stop after current instruction commits
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4 (link value for rd)
//  retired      out  CNT_W  count of committed instructions
//  halted       out  1   high in HALTED
//  trap         out  1   1-cycle pulse on misaligned target (MISALIGN_TRAP_EN only; tied 0 otherwise)
// BEHAVIOUR
//  States: RESET_S -> FETCH -> EXEC -> FETCH ...; EXEC -> HALTED on halt. Encoding in package.
//  Reset (rst_n low at edge): state=RESET_S, pc=RESET_PC, instr=0, retired=0; outputs next cycle:
//   imem_req=0, instr_valid=0, halted=0, trap=0. Reset mid-fetch/mid-exec aborts silently, no commit.
//  RESET_S: one idle cycle, -> FETCH unconditionally.
//  FETCH: imem_req=1, imem_addr=pc (combinational from state). On imem_ready: instr<=imem_rdata, -> EXEC.
//   imem_ready while not in FETCH is ignored. Minimum fetch latency 1 cycle (ready same cycle).
//  EXEC: instr_valid=1. exec_done sampled only here; elsewhere ignored. On exec_done:
//   pc<=pc_next, retired<=retired+1, -> FETCH (or HALTED if halt same cycle). halt without exec_done
//   is remembered (halt_q) and applied at the commit. Throughput: >=2 cycles/instruction.
//  pc_next: 00 -> (rs1+imm)&~1; 01 -> pc+imm; 10 -> alu_result==1 ? pc+imm : pc+4; 11 -> pc+4.
//   alu_result==2 or 0xFFFF_FFFF is NOT taken. All adds modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//  retired wraps at 2^CNT_W to 0. HALTED: sticky until reset, imem_req=0, pc frozen.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: at commit, if pc_next[1:0]!=0 then pc<=TRAP_VECTOR, trap pulses 1 cycle,
//   instruction still counts as retired; halt still honoured.
//  Undefined: pc_next committed unchanged (low bits kept), trap tied 0.
// STRUCTURE
//  fetch_pkg: fetch_state_t enum (RESET_S, FETCH, EXEC, HALTED); PC_SRC_JALR/JAL/BRANCH/SEQ 2-bit consts.
//  One sub-module: pc_selector (combinational next-PC mux, JALR LSB clear applied in sequencer).
//  Sequencer holds FSM, pc, instr, retired, halt_q.
// TESTING
//  1 Reset, imem_ready=1 always, pc_src=11 x3 -> imem_addr 0,4,8; retired=3; each instr 2 cycles.
//  2 pc=0x100, pc_src=10, imm=0x20: alu_result=1 -> pc 0x120; alu_result=2 -> pc 0x104.
//  3 pc_src=00 rs1=0x1001 imm=0x4 -> pc 0x1004; pc_src=01 pc=0x8 imm=-8 -> pc 0x0.
//  4 imem_ready low 5 cycles in FETCH -> imem_req/addr stable, instr_valid 0; rdata latched on 6th.
//  5 halt pulsed mid-EXEC, exec_done 3 cycles later -> commit, halted=1, imem_req stays 0; rst_n low
//   -> pc=RESET_PC, halted=0. Reset during FETCH -> no instr latched, retired unchanged (0).
//  6 MISALIGN_TRAP_EN: pc_src=01 pc=0 imm=6 -> trap 1 cycle, pc=0x10, retired+1; without macro pc=6.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    FETCH   = 2'd1,
    EXEC    = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PC_SRC_JALR   = 2'b00;
  localparam logic [1:0] PC_SRC_JAL    = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;
  localparam logic [1:0] PC_SRC_SEQ    = 2'b11;

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready handshake between the fetch sequencer and imem.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer_pc_selector.sv
// Combinational next-PC mux; JALR low-bit clearing is done by the caller.
module pc_selector
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_next
);

  // Select the successor PC from the execute-stage control.
  always_comb begin
    pc_next = pc + 32'd4;
    case (pc_src)
      PC_SRC_JALR:   pc_next = rs1 + imm;
      PC_SRC_JAL:    pc_next = pc + imm;
      PC_SRC_BRANCH: pc_next = (alu_result == 32'd1) ? (pc + imm) : (pc + 32'd4);
      PC_SRC_SEQ:    pc_next = pc + 32'd4;
      default:       pc_next = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller owning the architectural PC.
// Optional feature: MISALIGN_TRAP_EN redirects misaligned commit targets to TRAP_VECTOR.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010,
  parameter int          CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.master   imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic [1:0]          pc_src,
  input  logic [31:0]         rs1,
  input  logic [31:0]         imm,
  input  logic [31:0]         alu_result,
  input  logic                halt,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic [CNT_W-1:0]    retired,
  output logic                halted,
  output logic                trap
);

  fetch_state_t      state_r;
  logic [31:0]       pc_r;
  logic [31:0]       instr_r;
  logic [CNT_W-1:0]  retired_r;
  logic              halt_q_r;
  logic              req_r;
  logic              valid_r;
  logic              halted_r;
  logic              trap_r;

  logic [31:0]       sel_pc_s;
  logic [31:0]       target_s;
  logic [31:0]       commit_pc_s;
  logic              trap_s;

  pc_selector u_pc_selector (
    .pc         (pc_r),
    .pc_src     (pc_src),
    .rs1        (rs1),
    .imm        (imm),
    .alu_result (alu_result),
    .pc_next    (sel_pc_s)
  );

  // Resolve the committed PC, including JALR LSB clear and the optional trap redirect.
  always_comb begin
    target_s = (pc_src == PC_SRC_JALR) ? {sel_pc_s[31:1], 1'b0} : sel_pc_s;
`ifdef MISALIGN_TRAP_EN
    trap_s      = misaligned(target_s);
    commit_pc_s = trap_s ? TRAP_VECTOR : target_s;
`else
    trap_s      = 1'b0;
    commit_pc_s = target_s;
`endif
  end

  // Fetch/execute FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= RESET_S;
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      retired_r <= '0;
      halt_q_r  <= 1'b0;
      req_r     <= 1'b0;
      valid_r   <= 1'b0;
      halted_r  <= 1'b0;
      trap_r    <= 1'b0;
    end else begin
      trap_r <= 1'b0;
      case (state_r)
        RESET_S: begin
          state_r <= FETCH;
          req_r   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ready) begin
            instr_r <= imem.imem_rdata;
            state_r <= EXEC;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            pc_r      <= commit_pc_s;
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            trap_r    <= trap_s;
            valid_r   <= 1'b0;
            halt_q_r  <= 1'b0;
            // A halt seen at any point during EXEC takes effect at this commit.
            if (halt || halt_q_r) begin
              state_r  <= HALTED;
              halted_r <= 1'b1;
            end else begin
              state_r <= FETCH;
              req_r   <= 1'b1;
            end
          end else begin
            halt_q_r <= halt_q_r | halt;
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r  <= RESET_S;
          req_r    <= 1'b0;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign instr          = instr_r;
  assign instr_valid    = valid_r;
  assign pc             = pc_r;
  assign pc_plus4       = pc_r + 32'd4;
  assign retired        = retired_r;
  assign halted         = halted_r;
  assign trap           = trap_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: fetched words and committed PCs are queued and checked.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  pc_src = 2'b11;
  logic [31:0] rs1 = 32'h0000_0000;
  logic [31:0] imm = 32'h0000_0000;
  logic [31:0] alu_result = 32'h0000_0000;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        halted;
  logic        trap;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] model_pc = 32'h0000_0000;
  logic [31:0] model_ret = 32'h0000_0000;

  fetch_sequencer_if imem_bus();

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .pc_src      (pc_src),
    .rs1         (rs1),
    .imm         (imm),
    .alu_result  (alu_result),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired),
    .halted      (halted),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] addr);
    return addr ^ 32'h1300_0013;
  endfunction

  task automatic do_fetch(input int delay);
    int n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_val("fetch_addr", imem_bus.imem_addr, model_pc);
    for (int d = 0; d < delay; d++) begin
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'hBAD0_0000;
      @(negedge clk);
      check_val("stall_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check_val("stall_addr", imem_bus.imem_addr, model_pc);
      check_val("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = word_for(model_pc);
    exp_instr_q.push_back(word_for(model_pc));
    @(negedge clk);
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    check_val("instr_valid", {31'd0, instr_valid}, 32'd1);
    check_val("instr", instr, exp_instr_q.pop_front());
    check_val("req_in_exec", {31'd0, imem_bus.imem_req}, 32'd0);
  endtask

  task automatic do_exec(input logic [1:0] src, input logic [31:0] r1, input logic [31:0] im,
                         input logic [31:0] alu, input int wait_n, input bit halt_early,
                         input bit halt_now);
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    bit          exp_trap;
    bit          exp_halt;
    exp_halt = halt_early | halt_now;
    for (int w = 0; w < wait_n; w++) begin
      halt      = (w == 0) ? halt_early : 1'b0;
      exec_done = 1'b0;
      @(negedge clk);
      halt = 1'b0;
      check_val("exec_wait_valid", {31'd0, instr_valid}, 32'd1);
      check_val("exec_wait_instr", instr, word_for(model_pc));
    end
    case (src)
      2'b00:   tgt = (r1 + im) & 32'hFFFF_FFFE;
      2'b01:   tgt = model_pc + im;
      2'b10:   tgt = (alu == 32'd1) ? (model_pc + im) : (model_pc + 32'd4);
      default: tgt = model_pc + 32'd4;
    endcase
`ifdef MISALIGN_TRAP_EN
    exp_trap = (tgt[1:0] != 2'b00);
    exp_pc   = exp_trap ? 32'h0000_0010 : tgt;
`else
    exp_trap = 1'b0;
    exp_pc   = tgt;
`endif
    exp_pc_q.push_back(exp_pc);
    exec_done  = 1'b1;
    pc_src     = src;
    rs1        = r1;
    imm        = im;
    alu_result = alu;
    halt       = halt_now;
    @(negedge clk);
    exec_done = 1'b0;
    halt      = 1'b0;
    imem_bus.imem_ready = 1'b0;
    model_ret = model_ret + 32'd1;
    model_pc  = exp_pc_q.pop_front();
    check_val("commit_pc", pc, model_pc);
    check_val("retired", retired, model_ret);
    check_val("pc_plus4", pc_plus4, model_pc + 32'd4);
    check_val("trap", {31'd0, trap}, {31'd0, exp_trap});
    check_val("halted", {31'd0, halted}, {31'd0, exp_halt});
    check_val("next_req", {31'd0, imem_bus.imem_req}, {31'd0, !exp_halt});
    check_val("valid_after", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int c0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'h0000_0000;
    repeat (2) @(negedge clk);
    check_val("rst_pc", pc, 32'h0000_0000);
    check_val("rst_instr", instr, 32'h0000_0000);
    check_val("rst_retired", retired, 32'h0000_0000);
    check_val("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_trap", {31'd0, trap}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sequential fetches at two cycles per instruction
    for (int i = 0; i < 3; i++) begin
      c0 = cyc;
      do_fetch(0);
      do_exec(PC_SRC_SEQ, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
      check_val("cpi", cyc - c0, 32'd2);
    end

    // branches: only alu_result == 1 is taken
    do_fetch(0); do_exec(PC_SRC_JALR, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_BRANCH, 32'h0, 32'h0000_0020, 32'h0000_0001, 1, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_JALR, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_BRANCH, 32'h0, 32'h0000_0020, 32'h0000_0002, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_BRANCH, 32'h0, 32'h0000_0020, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_BRANCH, 32'h0, 32'h0000_0020, 32'h0000_0000, 0, 1'b0, 1'b0);

    // jumps, JALR LSB clear and 32-bit wrap
    do_fetch(0); do_exec(PC_SRC_JALR, 32'h0000_1001, 32'h0000_0004, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_JALR, 32'h0000_0008, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_JAL, 32'h0, 32'hFFFF_FFF8, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_JALR, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_SEQ, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // imem stall for five cycles
    do_fetch(5); do_exec(PC_SRC_SEQ, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // misaligned JAL target
    do_fetch(0); do_exec(PC_SRC_JALR, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_JAL, 32'h0, 32'h0000_0006, 32'h0, 0, 1'b0, 1'b0);
    do_fetch(0); do_exec(PC_SRC_SEQ, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // halt remembered across EXEC, applied at commit, then sticky
    do_fetch(0); do_exec(PC_SRC_SEQ, 32'h0, 32'h0, 32'h0, 3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exec_done = 1'b1;
      imem_bus.imem_ready = 1'b1;
      @(negedge clk);
      check_val("halt_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check_val("halt_flag", {31'd0, halted}, 32'd1);
      check_val("halt_pc", pc, model_pc);
      check_val("halt_retired", retired, model_ret);
    end
    exec_done = 1'b0;
    imem_bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst2_pc", pc, 32'h0000_0000);
    check_val("rst2_halted", {31'd0, halted}, 32'd0);
    check_val("rst2_retired", retired, 32'h0000_0000);
    model_pc  = 32'h0000_0000;
    model_ret = 32'h0000_0000;
    rst_n = 1'b1;
    @(negedge clk);

    // reset while a fetch is being accepted
    do_fetch(0); do_exec(PC_SRC_SEQ, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    check_val("pre_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hCAFE_F00D;
    rst_n = 1'b0;
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    check_val("rst3_instr", instr, 32'h0000_0000);
    check_val("rst3_retired", retired, 32'h0000_0000);
    check_val("rst3_pc", pc, 32'h0000_0000);
    check_val("rst3_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check_val("rst3_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
